// File: rtl/fifo_inst_master.sv
// Issuing side of the single-port FIFO instruction interface: builds {WE, RE, DI}, tracks occupancy, buffers read data.
// Optional FIFO_INST_SERIALIZE_EN keeps WE and RE out of the same inst word, alternating grants starting with pop.
module fifo_inst_master #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       push_ready,
    input  logic                       pop_valid,
    output logic                       pop_ready,
    output logic [DATA_W+1:0]          inst,
    input  logic [DATA_W-1:0]          res,
    input  logic                       read_valid,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       err_unexp
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);
    localparam int STL_W = OUT_W + 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  rsp_count;
    logic [STL_W-1:0]  stale;
    logic [STL_W-1:0]  stale_rst;
    logic [STL_W:0]    stale_sum;
    logic [OUT_W:0]    credit_used;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
    logic              push_ok, pop_ok, push_acc, pop_acc;
    logic              rv_stale, rv_take, rv_unexp, rsp_pop;
`ifdef FIFO_INST_SERIALIZE_EN
    logic              prio_pop;
    logic              conflict;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        credit_used = {1'b0, rsp_count} + {1'b0, outstanding};
        push_ok     = (occ != OCC_W'(DEPTH));
        pop_ok      = (occ != '0) && (credit_used < (OUT_W+1)'(RSP_DEPTH));
`ifdef FIFO_INST_SERIALIZE_EN
        conflict    = push_valid && pop_valid && push_ok && pop_ok;
        push_ready  = push_ok && !(conflict && prio_pop);
        pop_ready   = pop_ok && !(conflict && !prio_pop);
`else
        push_ready  = push_ok;
        pop_ready   = pop_ok;
`endif
        push_acc    = push_valid && push_ready;
        pop_acc     = pop_valid && pop_ready;
        // Returns for reads issued before the last reset arrive first (in-order) and are dropped.
        rv_stale    = read_valid && (stale != '0);
        rv_take     = read_valid && (stale == '0) && (outstanding != '0);
        rv_unexp    = read_valid && (stale == '0) && (outstanding == '0);
        rsp_pop     = (rsp_count != '0) && rsp_ready;
        stale_sum   = {1'b0, stale} + (STL_W+1)'(outstanding);
        if (read_valid && (stale_sum != '0)) begin
            stale_sum = stale_sum - (STL_W+1)'(1);
        end
        stale_rst   = stale_sum[STL_W] ? '1 : stale_sum[STL_W-1:0];
    end

    assign rsp_valid = (rsp_count != '0);
    assign rsp_data  = rsp_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            inst        <= '0;
            occ         <= '0;
            outstanding <= '0;
            rsp_count   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_unexp   <= 1'b0;
            stale       <= stale_rst;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem[i] <= '0;
            end
`ifdef FIFO_INST_SERIALIZE_EN
            prio_pop    <= 1'b1;
`endif
        end else begin
            inst <= {push_acc, pop_acc, push_acc ? push_data : inst[DATA_W-1:0]};

            case ({push_acc, pop_acc})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase

            case ({pop_acc, rv_take})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: ;
            endcase

            if (rv_stale) begin
                stale <= stale - STL_W'(1);
            end
            if (rv_unexp) begin
                err_unexp <= 1'b1;
            end

            if (rv_take) begin
                rsp_mem[wr_ptr] <= res;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (rsp_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({rv_take, rsp_pop})
                2'b10:   rsp_count <= rsp_count + OUT_W'(1);
                2'b01:   rsp_count <= rsp_count - OUT_W'(1);
                default: ;
            endcase
`ifdef FIFO_INST_SERIALIZE_EN
            if (conflict) begin
                prio_pop <= !prio_pop;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fifo_inst_master.sv
// Scoreboard bench for fifo_inst_master: queue-based reference model, wrapper model with in-order variable latency.
module tb_fifo_inst_master;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int RSP_DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       push_valid = 1'b0, pop_valid = 1'b0, rsp_ready = 1'b0, read_valid = 1'b0;
    logic [DATA_W-1:0]          push_data = '0, res = '0;
    logic                       push_ready, pop_ready, rsp_valid, err_unexp;
    logic [DATA_W-1:0]          rsp_data;
    logic [DATA_W+1:0]          inst;
    logic [$clog2(DEPTH+1)-1:0] occ;

    fifo_inst_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .inst(inst), .res(res), .read_valid(read_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .occ(occ), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, expected response order, credit counters.
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] exp_rsp[$];
    logic [DATA_W+1:0] exp_inst[$];
    logic [DATA_W-1:0] m_di = '0;
    int                m_outst = 0, m_rspcnt = 0, m_stale = 0;
    bit                m_err = 1'b0, m_prio_pop = 1'b1;

    // Wrapper model: storage plus in-order return pipeline.
    typedef struct { logic [DATA_W-1:0] d; int due; } ret_t;
    logic [DATA_W-1:0] w_mem[$];
    ret_t              w_ret[$];
    int                cyc = 0, lat_min = 1, lat_max = 3;
    bit                spurious = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_cycle(input bit r, input bit pv, input logic [DATA_W-1:0] pd,
                            input bit qv, input bit rr, output bit pacc, output bit qacc);
        bit   e_pr, e_qr, conflict, rsp_hs;
        int   sum;
        ret_t rt;
        @(negedge clk);
        cyc++;
        if (inst[DATA_W] === 1'b1 && w_mem.size() > 0) begin
            rt.d   = w_mem.pop_front();
            rt.due = cyc + int'($urandom_range(lat_max, lat_min));
            w_ret.push_back(rt);
        end
        if (inst[DATA_W+1] === 1'b1) w_mem.push_back(inst[DATA_W-1:0]);
        read_valid = 1'b0;
        if (spurious) begin
            read_valid = 1'b1;
            res        = 32'hDEAD;
            spurious   = 1'b0;
        end else if (w_ret.size() > 0 && w_ret[0].due <= cyc) begin
            rt         = w_ret.pop_front();
            read_valid = 1'b1;
            res        = rt.d;
        end
        rst = r; push_valid = pv; push_data = pd; pop_valid = qv; rsp_ready = rr;
        #1;
        e_pr     = (m_fifo.size() != DEPTH);
        e_qr     = (m_fifo.size() != 0) && (m_rspcnt + m_outst < RSP_DEPTH);
        conflict = 1'b0;
`ifdef FIFO_INST_SERIALIZE_EN
        if (pv && qv && e_pr && e_qr) begin
            conflict = 1'b1;
            if (m_prio_pop) e_pr = 1'b0;
            else            e_qr = 1'b0;
        end
`endif
        if (!r) begin
            check("push_ready", push_ready, e_pr);
            check("pop_ready", pop_ready, e_qr);
            check("occ", occ, m_fifo.size());
            check("rsp_valid", rsp_valid, m_rspcnt > 0);
            check("err_unexp", err_unexp, m_err);
        end
        pacc = !r && pv && e_pr;
        qacc = !r && qv && e_qr;
        if (r) begin
            sum = m_stale + m_outst;
            if (read_valid && sum > 0) sum--;
            m_stale = sum; m_outst = 0; m_rspcnt = 0; m_err = 1'b0; m_prio_pop = 1'b1; m_di = '0;
            m_fifo.delete(); exp_rsp.delete(); w_mem.delete();
            exp_inst.push_back('0);
        end else begin
            rsp_hs = (m_rspcnt > 0) && rr;
            if (read_valid) begin
                if (m_stale > 0)      m_stale--;
                else if (m_outst > 0) begin m_outst--; m_rspcnt++; end
                else                  m_err = 1'b1;
            end
            if (rsp_hs) m_rspcnt--;
            if (qacc) begin exp_rsp.push_back(m_fifo.pop_front()); m_outst++; end
            if (pacc) begin m_fifo.push_back(pd); m_di = pd; end
            exp_inst.push_back({pacc, qacc, m_di});
            if (conflict) m_prio_pop = !m_prio_pop;
        end
    endtask

    // Monitors: inst after each edge, response data on each downstream handshake.
    always @(posedge clk) begin
        #1;
        if (exp_inst.size() > 0) check("inst", inst, exp_inst.pop_front());
    end

    always @(negedge clk) begin
        #2;
        if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_extra: got %0h expected no response (cycle %0d)", rsp_data, cyc);
            end else begin
                check("rsp_data", rsp_data, exp_rsp.pop_front());
            end
        end
    end

    initial begin
        bit                pa, qa;
        logic [DATA_W-1:0] d;
        repeat (2) do_cycle(1, 0, '0, 0, 0, pa, qa);

        // Fill with 1..12; only 8 fit.
        d = 1;
        repeat (14) begin
            do_cycle(0, d <= 12, d, 0, 1, pa, qa);
            if (pa) d++;
        end
        check("fill_occ", occ, 8);
        check("fill_accepts", d, 9);

        // Drain.
        repeat (30) do_cycle(0, 0, '0, 1, 1, pa, qa);
        check("drain_occ", occ, 0);
        check("drain_pop_ready", pop_ready, 0);
        check("drain_err", err_unexp, 0);

        // Concurrent push 3 with pop.
        d = 1;
        repeat (2) begin do_cycle(0, 1, d, 0, 1, pa, qa); if (pa) d++; end
        for (int k = 0; k < 4 && d <= 3; k++) begin
            do_cycle(0, 1, d, k == 0, 1, pa, qa);
            if (pa) d++;
        end
        repeat (15) do_cycle(0, 0, '0, 1, 1, pa, qa);

        // Backpressure from downstream.
        d = 32'h100;
        repeat (6) begin do_cycle(0, 1, d, 0, 1, pa, qa); if (pa) d++; end
        repeat (12) do_cycle(0, 0, '0, 1, 0, pa, qa);
        check("bp_pop_ready", pop_ready, 0);
        check("bp_occ", occ, 2);
        repeat (10) do_cycle(0, 0, '0, 0, 1, pa, qa);
        repeat (15) do_cycle(0, 0, '0, 1, 1, pa, qa);

        // Spurious return.
        spurious = 1'b1;
        repeat (6) do_cycle(0, 0, '0, 0, 1, pa, qa);
        check("spur_err", err_unexp, 1);
        check("spur_rsp_valid", rsp_valid, 0);

        // Reset with occ=5 and two reads in flight.
        d = 32'h200;
        repeat (7) begin do_cycle(0, 1, d, 0, 1, pa, qa); if (pa) d++; end
        lat_min = 6; lat_max = 6;
        repeat (2) do_cycle(0, 0, '0, 1, 1, pa, qa);
        do_cycle(1, 0, '0, 0, 0, pa, qa);
        do_cycle(0, 0, '0, 0, 1, pa, qa);
        check("rst_inst", inst, 0);
        check("rst_occ", occ, 0);
        repeat (10) do_cycle(0, 0, '0, 0, 1, pa, qa);
        check("rst_late_err", err_unexp, 0);
        check("rst_late_rsp", rsp_valid, 0);
        lat_min = 1; lat_max = 3;

        // Random traffic.
        repeat (1500) begin
            do_cycle(0, $urandom_range(1, 0) == 1, $urandom, $urandom_range(1, 0) == 1,
                     $urandom_range(3, 0) != 0, pa, qa);
        end
        repeat (40) do_cycle(0, 0, '0, 1, 1, pa, qa);
        check("final_leftover", exp_rsp.size(), 0);
        check("final_err", err_unexp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_inst_master.md
Name: fifo_inst_master

Overview:
- Issuing end of the single-port FIFO instruction interface.
- Turns upstream push/pop handshakes into the 34-bit inst word {WE, RE, DI} consumed by the instruction FIFO wrapper.
- Tracks FIFO occupancy locally; the wrapper exposes no full/empty.
- Collects returned data (res qualified by read_valid) into a small response buffer with a valid/ready output.

Parameters:
- DATA_W, 32, data word width; inst width is DATA_W+2.
- DEPTH, 8, capacity of the attached FIFO in words.
- RSP_DEPTH, 4, entries in the local response buffer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- push_valid  in  1  upstream write request.
- push_data  in  DATA_W  word to write.
- push_ready  out  1  write request accepted this cycle.
- pop_valid  in  1  upstream read request.
- pop_ready  out  1  read request accepted this cycle.
- inst  out  DATA_W+2  {WE, RE, DI} to the FIFO wrapper, registered.
- res  in  DATA_W  read data from the wrapper.
- read_valid  in  1  res valid this cycle.
- rsp_valid  out  1  response buffer non-empty.
- rsp_data  out  DATA_W  head of response buffer.
- rsp_ready  in  1  downstream consumes head.
- occ  out  clog2(DEPTH+1)  words currently held in the FIFO, as tracked locally.
- err_unexp  out  1  sticky: read_valid arrived with no read outstanding.

Behaviour:
- Reset (rst=1 at posedge):
  - inst=0, occ=0, outstanding=0.
  - Response buffer emptied: rsp_valid=0, rsp_data=0.
  - err_unexp=0.
  - Applies mid-operation as well; responses for reads in flight at reset are dropped, with no error.
- push_ready = (occ != DEPTH), combinational.
- pop_ready = (occ != 0) && (rsp_count + outstanding < RSP_DEPTH). Credit scheme; the response buffer can never overflow.
- Accept rules:
  - Push accepted when push_valid && push_ready.
  - Pop accepted when pop_valid && pop_ready.
  - Both may be accepted in the same cycle.
- inst register, next cycle after accept:
  - WE = push accepted, RE = pop accepted.
  - DI = push_data if push accepted, else holds its last value.
  - Idle cycle: WE=RE=0.
  - One cycle of latency from accept to inst.
- occ update:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0, by construction.
  - Simultaneous push+pop at occ==DEPTH: pop accepted, push refused (push_ready=0 that cycle).
- outstanding counter:
  - +1 on pop accept, -1 on read_valid, net 0 when both occur.
  - Width clog2(RSP_DEPTH+1).
- read_valid with outstanding==0: err_unexp set (sticky until reset); data is discarded, buffer unchanged.
- Response buffer:
  - Circular, RSP_DEPTH entries; wrap-around pointers.
  - Write on read_valid (when expected), pop on rsp_valid && rsp_ready.
  - Simultaneous write and pop on an empty buffer: no bypass; data appears the next cycle.
  - Order of rsp_data equals order of pop accepts.
- No assumption on wrapper read latency beyond in-order return.

Optional Feature:
- Macro FIFO_INST_SERIALIZE_EN.
- Defined:
  - WE and RE are never asserted in the same inst word.
  - When push and pop are both valid and both otherwise ready, the grant alternates, starting with pop after reset.
  - The losing request sees ready=0 that cycle.
  - Used with wrapper builds that do not resolve port conflicts.
- Undefined: simultaneous WE=RE=1 is issued as described in Behaviour.

Test Plan:
- Fill: push_valid=1 with data 1..12 in consecutive cycles, pop_valid=0.
  - inst carries WE=1 with DI 1..8.
  - push_ready drops after 8 accepts; occ=8.
  - Words 9..12 are held upstream.
- Drain: after fill, pop_valid=1; wrapper model returns 1..8.
  - rsp_data = 1..8 in order.
  - occ reaches 0 and pop_ready=0.
  - err_unexp=0.
- Concurrent: push 1,2, then push 3 together with pop.
  - inst = {1,1,3} in the same cycle (macro off); occ stays 2.
  - Macro on: pop issued first, push of 3 the following cycle.
- Backpressure: rsp_ready=0 while popping.
  - pop_ready falls after 4 accepts (RSP_DEPTH=4).
  - Releasing rsp_ready yields 4 responses in order.
- Spurious: read_valid=1 with res=32'hDEAD and no read outstanding.
  - err_unexp=1 and stays 1.
  - rsp_valid stays 0.
- Reset mid-op: rst=1 for one cycle with occ=5 and 2 reads outstanding.
  - Next cycle: inst=0, occ=0, rsp_valid=0, err_unexp=0.
  - Late read_valid pulses are ignored.
